spi_mstr: RTL and testbench

//   Transmit-only SPI master used as a protocol-trigger stimulus source for the logic

---
 rtl/spi_mstr.sv | 178 +++++++++++++++++
 tb/tb_spi_mstr.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_mstr.sv
// ============================================================================
// Module      : spi_mstr
// Description : Transmit-only SPI master. On a wrt strobe in IDLE it sends
//               one 8- or 16-bit word, MSB first, on SS_n/SCLK/MOSI. SCLK
//               idles high. The slave-sampling edge is selected per frame by
//               pos_edge. All outputs are registered.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               wrt       - start strobe (accepted only in IDLE)
//               data_out  - word to send (width8=1 sends data_out[15:8])
//               pos_edge  - 1: slave samples on SCLK rise, 0: on SCLK fall
//               width8    - 1: 8-bit frame, 0: 16-bit frame
//               SS_n      - active-low slave select
//               SCLK      - serial clock
//               MOSI      - serial data out
//               done      - frame complete, sticky until next accepted wrt
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_mstr #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] data_out,
  input  logic        pos_edge,
  input  logic        width8,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done
);

  localparam int DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] HALF_END = DW'(SCLK_DIV / 2 - 1);
  localparam logic [DW-1:0] PER_END  = DW'(SCLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt, div_cnt_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [15:0]   shreg, shreg_nxt;
  logic          pos_edge_r, pos_edge_nxt;
  logic          width8_r, width8_nxt;
  logic          ss_nxt, sclk_nxt, mosi_nxt, done_nxt;
  logic          last_bit;

  // Current SCLK period carries the final bit of the frame.
  assign last_bit = (bit_cnt == (width8_r ? 4'd7 : 4'd15));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    pos_edge_nxt = pos_edge_r;
    width8_nxt   = width8_r;
    ss_nxt       = SS_n;
    sclk_nxt     = SCLK;
    mosi_nxt     = MOSI;
    done_nxt     = done;

    case (state)
      IDLE: begin
        ss_nxt   = 1'b1;
        sclk_nxt = 1'b1;
        if (wrt) begin
          shreg_nxt    = width8 ? {data_out[15:8], 8'h00} : data_out;
          pos_edge_nxt = pos_edge;
          width8_nxt   = width8;
          bit_cnt_nxt  = 4'd0;
          div_cnt_nxt  = '0;
          ss_nxt       = 1'b0;
          done_nxt     = 1'b0;
          mosi_nxt     = data_out[15];
          state_nxt    = FRONT;
        end
      end

      // SCLK held high for half a period so MOSI has setup before the
      // first edge. The fall that ends FRONT does not advance MOSI.
      FRONT: begin
        if (div_cnt == HALF_END) begin
          div_cnt_nxt = '0;
          sclk_nxt    = 1'b0;
          state_nxt   = SHIFT;
        end else begin
          div_cnt_nxt = div_cnt + DW'(1);
        end
      end

      // Each period: low half, then high half. MOSI changes on the edge
      // opposite to the slave's sampling edge.
      SHIFT: begin
        if (div_cnt == PER_END) begin
          div_cnt_nxt = '0;
          if (last_bit) begin
            state_nxt = BACK;
          end else begin
            sclk_nxt    = 1'b0;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (pos_edge_r) begin
              shreg_nxt = {shreg[14:0], 1'b0};
              mosi_nxt  = shreg[14];
            end
          end
        end else begin
          div_cnt_nxt = div_cnt + DW'(1);
          if (div_cnt == HALF_END) begin
            sclk_nxt = 1'b1;
            // No advance after the last falling-edge sample.
            if (!pos_edge_r && !last_bit) begin
              shreg_nxt = {shreg[14:0], 1'b0};
              mosi_nxt  = shreg[14];
            end
          end
        end
      end

      BACK: begin
        if (div_cnt == HALF_END) begin
          div_cnt_nxt = '0;
          ss_nxt      = 1'b1;
          done_nxt    = 1'b1;
          mosi_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else begin
          div_cnt_nxt = div_cnt + DW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bit_cnt    <= 4'd0;
      shreg      <= 16'h0000;
      pos_edge_r <= 1'b0;
      width8_r   <= 1'b0;
      SS_n       <= 1'b1;
      SCLK       <= 1'b1;
      MOSI       <= 1'b0;
      done       <= 1'b0;
    end else begin
      div_cnt    <= div_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      pos_edge_r <= pos_edge_nxt;
      width8_r   <= width8_nxt;
      SS_n       <= ss_nxt;
      SCLK       <= sclk_nxt;
      MOSI       <= mosi_nxt;
      done       <= done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_mstr.sv
// ============================================================================
// Module      : tb_spi_mstr
// Description : Directed self-checking bench for spi_mstr. A slave monitor
//               counts SCLK edges and SS_n-low cycles and shifts in MOSI on
//               the sampling edge selected for the current frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_mstr;

  localparam int SCLK_DIV = 32;

  logic        clk;
  logic        rst_n;
  logic        wrt;
  logic [15:0] data_out;
  logic        pos_edge;
  logic        width8;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  // Slave monitor state
  logic        mon_pos = 1'b0;
  logic        sclk_prev = 1'b1;
  logic [15:0] word = 16'h0000;
  int          rises = 0;
  int          falls = 0;
  int          low_cycles = 0;
  int          stray_edges = 0;

  spi_mstr #(.SCLK_DIV(SCLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrt      (wrt),
    .data_out (data_out),
    .pos_edge (pos_edge),
    .width8   (width8),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample away from the active edge; MOSI is stable across the chosen
  // sampling edge, so the post-edge value is the sampled bit.
  always @(negedge clk) begin
    if (!SS_n) begin
      low_cycles++;
      if (SCLK && !sclk_prev) begin
        rises++;
        if (mon_pos) word = {word[14:0], MOSI};
      end
      if (!SCLK && sclk_prev) begin
        falls++;
        if (!mon_pos) word = {word[14:0], MOSI};
      end
    end else if (SCLK != sclk_prev) begin
      stray_edges++;
    end
    sclk_prev = SCLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle wrt; returns at the negedge after the accepting edge.
  task automatic start(input logic [15:0] d, input logic w8, input logic pe);
    @(negedge clk);
    data_out = d;
    width8   = w8;
    pos_edge = pe;
    mon_pos  = pe;
    wrt      = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (done !== 1'b1 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  // Full frame: start, wait, and check edges, word, length and idle levels.
  task automatic run_frame(input string tag, input logic [15:0] d, input logic w8,
                           input logic pe, input logic [15:0] exp_word);
    int f0, r0, l0, s0, n;
    n  = w8 ? 8 : 16;
    f0 = falls; r0 = rises; l0 = low_cycles; s0 = stray_edges;
    start(d, w8, pe);
    check({tag, "_ss_low"}, {31'd0, SS_n}, 32'd0);
    check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    check({tag, "_msb"}, {31'd0, MOSI}, {31'd0, d[15]});
    wait_done({tag, "_done"});
    check({tag, "_falls"}, falls - f0, n);
    check({tag, "_rises"}, rises - r0, n);
    check({tag, "_word"}, w8 ? {24'd0, word[7:0]} : {16'd0, word}, {16'd0, exp_word});
    check({tag, "_len"}, {31'd0, ((low_cycles - l0) >= (n + 1) * SCLK_DIV - 1) &&
                                 ((low_cycles - l0) <= (n + 1) * SCLK_DIV + 1)}, 32'd1);
    check({tag, "_stray"}, stray_edges - s0, 0);
    check({tag, "_ss_end"}, {31'd0, SS_n}, 32'd1);
    check({tag, "_sclk_end"}, {31'd0, SCLK}, 32'd1);
    check({tag, "_mosi_end"}, {31'd0, MOSI}, 32'd0);
  endtask

  initial begin
    int f0, r0, l0;
    rst_n    = 1'b0;
    wrt      = 1'b0;
    data_out = 16'h0000;
    pos_edge = 1'b0;
    width8   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ss", {31'd0, SS_n}, 32'd1);
    check("rst_sclk", {31'd0, SCLK}, 32'd1);
    check("rst_mosi", {31'd0, MOSI}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8-bit, slave samples on fall
    run_frame("f8neg", 16'h6600, 1'b1, 1'b0, 16'h0066);

    // 16-bit, slave samples on rise
    run_frame("f16pos", 16'hA5C3, 1'b0, 1'b1, 16'hA5C3);

    // wrt mid-frame with different data/mode is ignored
    f0 = falls; r0 = rises; l0 = low_cycles;
    start(16'h1234, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    data_out = 16'hFFFF;
    width8   = 1'b1;
    pos_edge = 1'b1;
    wrt      = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    wait_done("mid_done");
    check("mid_falls", falls - f0, 16);
    check("mid_rises", rises - r0, 16);
    check("mid_word", {16'd0, word}, 32'h1234);
    check("mid_len", low_cycles - l0, 17 * SCLK_DIV);

    // Reset during bit 5
    start(16'hFFFF, 1'b0, 1'b1);
    repeat (SCLK_DIV / 2 + 5 * SCLK_DIV + 8) @(negedge clk);
    check("pre_rst_mosi", {31'd0, MOSI}, 32'd1);
    check("pre_rst_ss", {31'd0, SS_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mrst_ss", {31'd0, SS_n}, 32'd1);
    check("mrst_sclk", {31'd0, SCLK}, 32'd1);
    check("mrst_mosi", {31'd0, MOSI}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_done", {31'd0, done}, 32'd0);
    run_frame("after_rst", 16'h0F0F, 1'b0, 1'b1, 16'h0F0F);

    // Back-to-back: wrt in the first IDLE cycle after done
    run_frame("b2b_a", 16'h3C00, 1'b1, 1'b1, 16'h003C);
    f0 = falls; r0 = rises;
    data_out = 16'hC300;
    width8   = 1'b1;
    pos_edge = 1'b0;
    mon_pos  = 1'b0;
    wrt      = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    check("b2b_done_clr", {31'd0, done}, 32'd0);
    check("b2b_ss_low", {31'd0, SS_n}, 32'd0);
    wait_done("b2b_b_done");
    check("b2b_b_falls", falls - f0, 8);
    check("b2b_b_rises", rises - r0, 8);
    check("b2b_b_word", {24'd0, word[7:0]}, 32'h00C3);

    repeat (4) @(negedge clk);
    check("idle_sclk", {31'd0, SCLK}, 32'd1);
    check("done_sticky", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
